// File: rtl/packet_sink_pkg.sv
// Shared flit-channel definitions: head-bit position, flit kinds and receiver state encoding.
// Used by packet_sink and by the upstream packet source.
package packet_sink_pkg;

  localparam logic FLIT_HEAD = 1'b1;
  localparam logic FLIT_BODY = 1'b0;

  typedef enum logic {
    IDLE = 1'b0,
    WAIT = 1'b1
  } rx_state_t;

  // The head marker always occupies the MSB of a flit.
  function automatic int head_bit(input int size);
    return size - 1;
  endfunction

endpackage

// File: rtl/packet_sink_twophase_rx.sv
// Two-phase (toggle) req/ack receiver: detects req edges, optionally delays the ack toggle,
// flags req toggles that arrive while an ack is still pending, and emits a capture strobe.
module twophase_rx
  import packet_sink_pkg::*;
#(
  parameter int ACK_DELAY = 0
) (
  input  logic clk,
  input  logic reset,
  input  logic i_req,
  output logic o_ack,
  output logic o_busy,
  output logic o_proto_err,
  output logic o_capture
);

  localparam logic [7:0] DLY = 8'(ACK_DELAY);

  rx_state_t  r_state, w_state_n;
  logic       r_req_prev;
  logic       r_ack, w_ack_n;
  logic       r_busy, w_busy_n;
  logic       r_proto_err, w_proto_err_n;
  logic [7:0] r_cnt, w_cnt_n;
  logic       w_req_event;

  assign w_req_event = i_req ^ r_req_prev;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state     <= IDLE;
      r_req_prev  <= 1'b0;
      r_ack       <= 1'b0;
      r_busy      <= 1'b0;
      r_proto_err <= 1'b0;
      r_cnt       <= 8'd0;
    end else begin
      r_state     <= w_state_n;
      r_req_prev  <= i_req;
      r_ack       <= w_ack_n;
      r_busy      <= w_busy_n;
      r_proto_err <= w_proto_err_n;
      r_cnt       <= w_cnt_n;
    end
  end

  always_comb begin
    w_state_n     = r_state;
    w_ack_n       = r_ack;
    w_busy_n      = r_busy;
    w_proto_err_n = r_proto_err;
    w_cnt_n       = r_cnt;
    o_capture     = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_req_event) begin
          o_capture = 1'b1;
          if (ACK_DELAY == 0) begin
            w_ack_n = ~r_ack;
          end else begin
            w_cnt_n   = DLY;
            w_busy_n  = 1'b1;
            w_state_n = WAIT;
          end
        end
      end
      WAIT: begin
        // A new offer before the previous ack is dropped, never captured.
        if (w_req_event) w_proto_err_n = 1'b1;
        if (r_cnt == 8'd1) begin
          w_ack_n   = ~r_ack;
          w_busy_n  = 1'b0;
          w_cnt_n   = 8'd0;
          w_state_n = IDLE;
        end else begin
          w_cnt_n = r_cnt - 8'd1;
        end
      end
      default: w_state_n = IDLE;
    endcase
  end

  assign o_ack       = r_ack;
  assign o_busy      = r_busy;
  assign o_proto_err = r_proto_err;

endmodule

// File: rtl/packet_sink.sv
// Packet sink: terminates a two-phase flit channel, reassembles FLITS flits per packet and checks framing.
// Optional resynchronisation on framing errors is enabled by defining PACKET_SINK_RESYNC_EN.
module packet_sink
  import packet_sink_pkg::*;
#(
  parameter int ID        = 0,
  parameter int FLITS     = 8,
  parameter int SIZE      = 8,
  parameter int ACK_DELAY = 0
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  i_req,
  output logic                  o_ack,
  input  logic [SIZE-1:0]       i_data,
  output logic                  o_pkt_valid,
  output logic [FLITS*SIZE-1:0] o_pkt_data,
  output logic [7:0]            o_pkt_count,
  output logic                  o_frame_err,
  output logic                  o_proto_err,
  output logic                  o_busy
);

  localparam int         HB   = head_bit(SIZE);
  localparam logic [7:0] LAST = 8'(FLITS - 1);

  logic                  w_capture;
  logic                  w_head;
  logic                  w_first;
  logic                  w_ferr;
  logic                  w_drop;
  logic                  w_last;
  logic [7:0]            w_slot;
  logic [FLITS*SIZE-1:0] w_buf_next;

  logic [7:0]            r_idx;
  logic [FLITS*SIZE-1:0] r_buf;
  logic                  r_pkt_valid;
  logic [FLITS*SIZE-1:0] r_pkt_data;
  logic [7:0]            r_pkt_count;
  logic                  r_frame_err;

  twophase_rx #(
    .ACK_DELAY (ACK_DELAY)
  ) u_rx (
    .clk         (clk),
    .reset       (reset),
    .i_req       (i_req),
    .o_ack       (o_ack),
    .o_busy      (o_busy),
    .o_proto_err (o_proto_err),
    .o_capture   (w_capture)
  );

  assign w_head  = i_data[HB];
  assign w_first = (r_idx == 8'd0);
  assign w_ferr  = w_first ? (w_head != FLIT_HEAD) : (w_head != FLIT_BODY);

`ifdef PACKET_SINK_RESYNC_EN
  // A stray body is acked but thrown away; a late head restarts the packet in slot 0.
  assign w_drop = w_first && (w_head == FLIT_BODY);
  assign w_slot = (w_head == FLIT_HEAD) ? 8'd0 : r_idx;
`else
  assign w_drop = 1'b0;
  assign w_slot = r_idx;
`endif

  assign w_last = (w_slot == LAST);

  always_comb begin
    w_buf_next = r_buf;
    w_buf_next[int'(w_slot)*SIZE +: SIZE] = i_data;
  end

  // Flit buffer is pure data: every slot is rewritten before it can reach o_pkt_data.
  always_ff @(posedge clk) begin
    if (w_capture && !w_drop) r_buf <= w_buf_next;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_idx       <= 8'd0;
      r_pkt_valid <= 1'b0;
      r_pkt_data  <= '0;
      r_pkt_count <= 8'd0;
      r_frame_err <= 1'b0;
    end else begin
      r_pkt_valid <= 1'b0;
      if (w_capture) begin
        if (w_ferr) r_frame_err <= 1'b1;
        if (!w_drop) begin
          if (w_last) begin
            r_idx       <= 8'd0;
            r_pkt_data  <= w_buf_next;
            r_pkt_valid <= 1'b1;
            r_pkt_count <= r_pkt_count + 8'd1;
          end else begin
            r_idx <= w_slot + 8'd1;
          end
        end
      end
    end
  end

  assign o_pkt_valid = r_pkt_valid;
  assign o_pkt_data  = r_pkt_data;
  assign o_pkt_count = r_pkt_count;
  assign o_frame_err = r_frame_err;

endmodule

// File: tb/tb_packet_sink.sv
// Bench for packet_sink: two instances (ACK_DELAY 0 and 3) driven by a toggle-protocol source,
// checked against a packet-level reference model.
module tb_packet_sink;

`ifdef PACKET_SINK_RESYNC_EN
  localparam bit RESYNC = 1'b1;
`else
  localparam bit RESYNC = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        req0 = 1'b0, req3 = 1'b0;
  logic [7:0]  data0 = 8'd0, data3 = 8'd0;
  logic        ack0, ack3, pv0, pv3, fe0, fe3, pe0, pe3, busy0, busy3;
  logic [63:0] pd0, pd3;
  logic [7:0]  pc0, pc3;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model state, index 0 = ACK_DELAY 0 instance, index 1 = ACK_DELAY 3 instance.
  logic [7:0]  m_buf [2][8];
  int          m_idx [2];
  logic [7:0]  m_cnt [2];
  logic        m_ferr[2];
  logic        m_perr[2];
  logic        m_ack [2];
  logic [63:0] m_pkt [2];

  always #5 clk = ~clk;

  packet_sink #(.ID(0), .FLITS(8), .SIZE(8), .ACK_DELAY(0)) dut0 (
    .clk(clk), .reset(reset), .i_req(req0), .o_ack(ack0), .i_data(data0),
    .o_pkt_valid(pv0), .o_pkt_data(pd0), .o_pkt_count(pc0),
    .o_frame_err(fe0), .o_proto_err(pe0), .o_busy(busy0));

  packet_sink #(.ID(3), .FLITS(8), .SIZE(8), .ACK_DELAY(3)) dut3 (
    .clk(clk), .reset(reset), .i_req(req3), .o_ack(ack3), .i_data(data3),
    .o_pkt_valid(pv3), .o_pkt_data(pd3), .o_pkt_count(pc3),
    .o_frame_err(fe3), .o_proto_err(pe3), .o_busy(busy3));

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic void model_reset();
    for (int s = 0; s < 2; s++) begin
      m_idx[s] = 0; m_cnt[s] = 8'd0; m_ferr[s] = 1'b0;
      m_perr[s] = 1'b0; m_ack[s] = 1'b0; m_pkt[s] = 64'd0;
    end
  endfunction

  // Returns 1 when the flit completes a packet.
  function automatic bit model_accept(input int s, input logic [7:0] f);
    bit head;
    head = f[7];
    if (head != (m_idx[s] == 0)) m_ferr[s] = 1'b1;
    if (RESYNC) begin
      if (!head && m_idx[s] == 0) return 1'b0;
      if (head) m_idx[s] = 0;
    end
    m_buf[s][m_idx[s]] = f;
    m_idx[s]++;
    if (m_idx[s] == 8) begin
      m_idx[s] = 0;
      m_cnt[s] = m_cnt[s] + 8'd1;
      for (int k = 0; k < 8; k++) m_pkt[s][k*8 +: 8] = m_buf[s][k];
      return 1'b1;
    end
    return 1'b0;
  endfunction

  function automatic logic [7:0] rand_head();
    return 8'h80 | 8'($urandom_range(0, 127));
  endfunction

  function automatic logic [7:0] rand_body();
    return 8'($urandom_range(0, 127));
  endfunction

  // Offers one flit at a negedge and checks ack/busy timing and the packet outputs.
  task automatic send(input int s, input logic [7:0] f, input string tag);
    int lat;
    bit done;
    lat = (s == 0) ? 1 : 4;
    if (s == 0) begin req0 = ~req0; data0 = f; end
    else        begin req3 = ~req3; data3 = f; end
    done = model_accept(s, f);
    for (int n = 1; n <= lat; n++) begin
      @(negedge clk);
      if (n == 1) chk({tag, " pkt_valid"}, (s == 0) ? pv0 : pv3, done);
      if (n < lat) begin
        chk({tag, " busy_wait"}, busy3, 1'b1);
        chk({tag, " ack_early"}, ack3, m_ack[s]);
      end
    end
    m_ack[s] = ~m_ack[s];
    chk({tag, " ack"}, (s == 0) ? ack0 : ack3, m_ack[s]);
    chk({tag, " busy"}, (s == 0) ? busy0 : busy3, 1'b0);
    chk({tag, " count"}, (s == 0) ? pc0 : pc3, m_cnt[s]);
    chk({tag, " frame_err"}, (s == 0) ? fe0 : fe3, m_ferr[s]);
    chk({tag, " proto_err"}, (s == 0) ? pe0 : pe3, m_perr[s]);
    if (done) chk({tag, " pkt_data"}, (s == 0) ? pd0 : pd3, m_pkt[s]);
  endtask

  task automatic send_pkt(input int s, input string tag);
    send(s, rand_head(), tag);
    for (int k = 1; k < 8; k++) send(s, rand_body(), tag);
  endtask

  task automatic do_reset(input string tag);
    @(negedge clk);
    reset = 1'b1;
    req0 = 1'b0;
    req3 = 1'b0;
    model_reset();
    #1;
    chk({tag, " rst ack"}, ack0, 1'b0);
    chk({tag, " rst pkt_valid"}, pv0, 1'b0);
    chk({tag, " rst pkt_data"}, pd0, 64'd0);
    chk({tag, " rst count"}, pc0, 8'd0);
    chk({tag, " rst frame_err"}, fe0, 1'b0);
    chk({tag, " rst proto_err"}, pe3, 1'b0);
    chk({tag, " rst busy"}, busy3, 1'b0);
    chk({tag, " rst ack3"}, ack3, 1'b0);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] fa;
    model_reset();
    do_reset("init");

    // Two clean packets, immediate ack.
    send_pkt(0, "clean0");
    send_pkt(0, "clean1");
    chk("two_pkts count", pc0, 8'd2);

    // Delayed ack: single head flit, then finish that packet.
    send(1, 8'h85, "delay");
    for (int k = 1; k < 8; k++) send(1, rand_body(), "delay_body");

    // Second offer while the first is still waiting for its ack.
    fa = rand_head();
    req3 = ~req3; data3 = fa;
    void'(model_accept(1, fa));
    @(negedge clk);
    req3 = ~req3; data3 = rand_body();
    m_perr[1] = 1'b1;
    repeat (3) @(negedge clk);
    m_ack[1] = ~m_ack[1];
    chk("proto ack_once", ack3, m_ack[1]);
    chk("proto err", pe3, 1'b1);
    repeat (4) @(negedge clk);
    chk("proto no_second_ack", ack3, m_ack[1]);
    chk("proto busy_clear", busy3, 1'b0);
    for (int k = 1; k < 8; k++) send(1, rand_body(), "proto_body");

    // Stray body flit followed by a clean packet.
    send(0, 8'h12, "frame_stray");
    send_pkt(0, "frame_pkt");
    chk("frame sticky", fe0, 1'b1);

    // Reset in the middle of a packet.
    do_reset("pre_mid");
    for (int k = 0; k < 4; k++) send(0, (k == 0) ? rand_head() : rand_body(), "partial");
    do_reset("mid");
    send_pkt(0, "after_rst");
    chk("after_rst count", pc0, 8'd1);
    chk("after_rst frame_err", fe0, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/packet_sink.md
Name: packet_sink

Overview:
- Consumer stage directly downstream of the packet source.
- Terminates a two-phase (toggle) req/ack flit channel and reassembles flits into whole packets.
- Checks head/body framing on every flit and exposes each completed packet, a packet count and error flags to the bench or monitor.
- Same clock domain as the producer; no synchroniser is required.

Parameters:
- ID, 0: instance identifier, used only in debug messages.
- FLITS, 8: flits per packet, 1..255.
- SIZE, 8: flit width in bits. Bit SIZE-1 is the head marker.
- ACK_DELAY, 0: extra cycles between flit capture and the ack toggle, 0..255.

Ports:
- clk  in  1  clock.
- reset  in  1  asynchronous, active-high.
- req  in  1  two-phase request; each toggle offers one flit.
- ack  out  1  two-phase acknowledge; each toggle releases one flit.
- data  in  SIZE  flit payload; valid whenever a req toggle is detected.
- pkt_valid  out  1  one-cycle pulse when a packet completes.
- pkt_data  out  FLITS*SIZE  last completed packet; flit 0 in bits [SIZE-1:0]; holds until the next completion.
- pkt_count  out  8  completed packets; wraps 255->0.
- frame_err  out  1  sticky framing error.
- proto_err  out  1  sticky protocol error.
- busy  out  1  high while a captured flit awaits its ack.

Behaviour:
- Reset values (async): ack=0, pkt_valid=0, pkt_data=0, pkt_count=0, frame_err=0, proto_err=0, busy=0. Internal: req_prev=0, flit_idx=0, delay counter=0, state=IDLE.
- Reset mid-packet discards the partial packet.
- req_event = req ^ req_prev. req_prev <= req every cycle.
- State IDLE, on req_event:
  - write data into buffer[flit_idx];
  - perform the framing check;
  - if ACK_DELAY==0, toggle ack at the same edge, so ack changes 1 cycle after the req toggle is sampled, and stay in IDLE;
  - else load counter=ACK_DELAY, set busy=1, go to WAIT.
- State WAIT:
  - decrement the counter each cycle;
  - when the counter is 1, toggle ack, clear busy, return to IDLE;
  - ack therefore changes ACK_DELAY+1 cycles after capture.
- req_event while in WAIT is a protocol violation: proto_err<=1, the flit is ignored and not acked.
- Framing check:
  - flit_idx==0 expects data[SIZE-1]==1;
  - flit_idx>0 expects data[SIZE-1]==0;
  - a mismatch sets frame_err.
- Flit index: increments per accepted flit. On capture at flit_idx==FLITS-1:
  - flit_idx<=0;
  - pkt_data<={buffer with the new flit};
  - pkt_valid<=1 for one cycle;
  - pkt_count<=pkt_count+1.
- The packet is completed even when it contains a framing error (without RESYNC; see below).
- FLITS==1: every flit completes a packet. Each flit must be a head.
- Simultaneous last-flit completion and ack toggle in the same edge is legal and the normal case for ACK_DELAY==0.

Optional Feature:
- Macro PACKET_SINK_RESYNC_EN.
- Without the macro: framing errors only set the sticky frame_err; indexing is unchanged.
- With the macro, framing errors still set frame_err and the sink resynchronises:
  - a head flit at flit_idx>0 abandons the partial packet, is stored as flit 0, and sets flit_idx=1 (for FLITS==1 it completes immediately);
  - a body flit at flit_idx==0 is acked but discarded, and flit_idx stays 0.
- Ack timing is identical in both builds.

Decomposition:
- Shared package/include (noc_defs): head-bit index macro (SIZE-1), FLIT_HEAD=1 and FLIT_BODY=0, state encodings IDLE/WAIT. The packet source uses the same package.
- Sub-module twophase_rx: req edge detect, ACK_DELAY counter, ack toggle, busy and proto_err generation. It outputs a one-cycle capture strobe.
- packet_sink instantiates twophase_rx and keeps the buffer, framing and count logic.

Test Plan:
- Reset, then the source sends 2 packets, FLITS=8, SIZE=8, first flit 0x80|x, bodies <0x80, ACK_DELAY=0 -> each ack toggles 1 cycle after the req toggle; pkt_valid pulses twice; pkt_count=2; frame_err=0; pkt_data equals the sent flits with flit 0 in the LSBs.
- ACK_DELAY=3, single flit 0x85 -> busy high for 3 cycles; ack toggles 4 cycles after capture.
- ACK_DELAY=3, second req toggle 1 cycle after the first -> proto_err=1; second flit not acked; flit_idx=1.
- Body flit 0x12 first, then a correct 8-flit packet, default build -> frame_err=1; pkt_valid fires after flit 8, with pkt_data containing 0x12 as flit 0.
- Same stimulus, PACKET_SINK_RESYNC_EN -> 0x12 acked and dropped; pkt_valid after the 9th flit; pkt_data equals the clean packet; frame_err=1.
- Assert reset after 4 flits, then send a full packet -> outputs return to reset values; the next 8 flits form one clean packet; pkt_count=1.
